// File: rtl/ascon_block_loader.sv
// ASCON-AEAD128 input stage: packs 32-bit host words into rate blocks and presents them to the FSM.
// Optional build macro ASCON_LOADER_PAD_EN enables hardware 10* padding and the extra pad block.
module ascon_block_loader #(
  parameter int unsigned NB_WORDS = 4
) (
  input  logic                    clock_i,
  input  logic                    resetb_i,
  input  logic [31:0]             word_i,
  input  logic                    word_valid_i,
  input  logic                    word_last_i,
  input  logic [2:0]              word_bytes_i,
  input  logic                    pad_only_i,
  output logic                    word_ready_o,
  output logic [32*NB_WORDS-1:0]  block_o,
  output logic                    data_valid_o,
  output logic                    block_last_o,
  input  logic                    block_done_i
);

  localparam int unsigned CntW    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam int unsigned NbBytes = 4 * NB_WORDS;

  typedef enum logic [1:0] {StFill, StPresent, StWait, StPad} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [32*NB_WORDS-1:0] block_q, block_d;
  logic                   last_q, last_d;
  logic                   pad_pend_q, pad_pend_d;

  logic [31:0]            word_masked;
  logic                   slot_full;
  int unsigned            nb;
  int unsigned            n;

  // Byte count of the incoming word and resulting message length within the block.
  always_comb begin
    nb = 4;
    if (word_last_i && (word_bytes_i inside {3'd1, 3'd2, 3'd3})) begin
      nb = 32'(word_bytes_i);
    end
    n = 32'(cnt_q) * 4 + nb;
    for (int unsigned j = 0; j < 4; j++) begin
      word_masked[8*j +: 8] = (j < nb) ? word_i[8*j +: 8] : 8'h00;
    end
  end

  assign slot_full = (32'(cnt_q) == NB_WORDS - 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    block_d    = block_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;
    unique case (state_q)
      StFill: begin
        if (word_valid_i) begin
          for (int unsigned w = 0; w < NB_WORDS; w++) begin
            if (w == 32'(cnt_q)) block_d[32*w +: 32] = word_masked;
          end
          if (word_last_i) begin
            state_d = StPresent;
`ifdef ASCON_LOADER_PAD_EN
            if (n < NbBytes) begin
              // Pad byte lands in later (already zero) slots when the last word is full.
              for (int unsigned k = 0; k < NbBytes; k++) begin
                if (k == n) block_d[8*k +: 8] = 8'h01;
              end
              last_d = 1'b1;
            end else begin
              last_d     = 1'b0;
              pad_pend_d = 1'b1;
            end
`else
            last_d = 1'b1;
`endif
          end else if (slot_full) begin
            state_d = StPresent;
            last_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (pad_only_i && (cnt_q == '0)) begin
          state_d = StPad;
        end
      end
      StPresent: state_d = StWait;
      StWait: begin
        if (block_done_i) begin
          if (pad_pend_q) begin
            state_d    = StPad;
            pad_pend_d = 1'b0;
          end else begin
            state_d = StFill;
            cnt_d   = '0;
            block_d = '0;
            last_d  = 1'b0;
          end
        end
      end
      StPad: begin
        block_d = '0;
`ifdef ASCON_LOADER_PAD_EN
        block_d[7:0] = 8'h01;
`endif
        last_d  = 1'b1;
        state_d = StPresent;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q    <= StFill;
      cnt_q      <= '0;
      block_q    <= '0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      block_q    <= block_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
    end
  end

  assign word_ready_o = (state_q == StFill);
  assign data_valid_o = (state_q == StPresent);
  assign block_o      = block_q;
  assign block_last_o = last_q;

endmodule

// File: tb/tb_ascon_block_loader.sv
// Directed bench for ascon_block_loader: table of single-block messages plus multi-cycle sequences.
module tb_ascon_block_loader;

`ifdef ASCON_LOADER_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  logic         clk;
  logic         resetb;
  logic [31:0]  word_i;
  logic         word_valid_i;
  logic         word_last_i;
  logic [2:0]   word_bytes_i;
  logic         pad_only_i;
  logic         word_ready_o;
  logic [127:0] block_o;
  logic         data_valid_o;
  logic         block_last_o;
  logic         done_man;
  logic         done_auto;

  ascon_block_loader #(.NB_WORDS(4)) dut (
    .clock_i      (clk),
    .resetb_i     (resetb),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_last_i  (word_last_i),
    .word_bytes_i (word_bytes_i),
    .pad_only_i   (pad_only_i),
    .word_ready_o (word_ready_o),
    .block_o      (block_o),
    .data_valid_o (data_valid_o),
    .block_last_o (block_last_o),
    .block_done_i (done_man | done_auto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse counter / capture and an automatic block_done responder (3 cycles after each pulse).
  int           dv_count = 0;
  logic [127:0] cap_block [8];
  logic         cap_last  [8];
  bit           auto_en = 1'b0;
  int           auto_cd = 0;

  initial done_auto = 1'b0;
  always @(negedge clk) begin
    done_auto <= 1'b0;
    if (data_valid_o) begin
      cap_block[dv_count % 8] = block_o;
      cap_last[dv_count % 8]  = block_last_o;
      dv_count++;
      if (auto_en) auto_cd = 3;
    end else if (auto_cd > 0) begin
      auto_cd--;
      if (auto_cd == 0) done_auto <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic lst, input logic [2:0] nb);
    int guard;
    guard        = 0;
    word_i       = w;
    word_last_i  = lst;
    word_bytes_i = nb;
    word_valid_i = 1'b1;
    while (!word_ready_o && guard < 50) begin
      step();
      guard++;
    end
    chk("word_ready_wait", 128'(word_ready_o), 128'(1));
    step();
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
  endtask

  task automatic pulse_done();
    done_man = 1'b1;
    step();
    done_man = 1'b0;
  endtask

  typedef struct {
    logic [127:0] words;
    int unsigned  nw;
    logic [2:0]   nb;
    logic [127:0] exp_pad;
    logic [127:0] exp_raw;
    logic         full;
  } vec_t;

  vec_t vecs [7];

  task automatic set_vec(input int i, input logic [127:0] words, input int unsigned nw,
                         input logic [2:0] nb, input logic [127:0] ep, input logic [127:0] er,
                         input logic full);
    vecs[i].words   = words;
    vecs[i].nw      = nw;
    vecs[i].nb      = nb;
    vecs[i].exp_pad = ep;
    vecs[i].exp_raw = er;
    vecs[i].full    = full;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp_b;
    logic         exp_l;
    logic [127:0] b2b_words;
    int           base;

    resetb       = 1'b0;
    word_i       = '0;
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
    word_bytes_i = '0;
    pad_only_i   = 1'b0;
    done_man     = 1'b0;

    set_vec(0, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 4, 3'd4,
            128'h0F0E0D0C_0B0A0908_07060504_03020100,
            128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1);
    set_vec(1, 128'h00000000_00000000_EECCBBAA_44332211, 2, 3'd3,
            128'h00000000_00000000_01CCBBAA_44332211,
            128'h00000000_00000000_00CCBBAA_44332211, 1'b0);
    set_vec(2, 128'h00000000_00000000_00000000_DEADBEEF, 1, 3'd1,
            128'h00000000_00000000_00000000_000001EF,
            128'h00000000_00000000_00000000_000000EF, 1'b0);
    set_vec(3, 128'h00000000_00000000_00000000_11223344, 1, 3'd0,
            128'h00000000_00000000_00000001_11223344,
            128'h00000000_00000000_00000000_11223344, 1'b0);
    set_vec(4, 128'h00000000_C0C1C2C3_B0B1B2B3_A0A1A2A3, 3, 3'd2,
            128'h00000000_0001C2C3_B0B1B2B3_A0A1A2A3,
            128'h00000000_0000C2C3_B0B1B2B3_A0A1A2A3, 1'b0);
    set_vec(5, 128'h55667788_00000003_00000002_00000001, 4, 3'd2,
            128'h00017788_00000003_00000002_00000001,
            128'h00007788_00000003_00000002_00000001, 1'b0);
    set_vec(6, 128'h00000000_00000003_00000002_00000001, 3, 3'd4,
            128'h00000001_00000003_00000002_00000001,
            128'h00000000_00000003_00000002_00000001, 1'b0);

    // Reset values while reset is held across a clock edge.
    #12;
    chk("rst_ready", 128'(word_ready_o), 128'(1));
    chk("rst_valid", 128'(data_valid_o), 128'(0));
    chk("rst_last",  128'(block_last_o), 128'(0));
    chk("rst_block", block_o, 128'(0));
    @(negedge clk);
    resetb = 1'b1;
    step();

    // Table of single-block messages.
    for (int v = 0; v < 7; v++) begin
      exp_b = PadEn ? vecs[v].exp_pad : vecs[v].exp_raw;
      exp_l = PadEn ? !vecs[v].full : 1'b1;
      for (int unsigned i = 0; i < vecs[v].nw; i++) begin
        send_word(vecs[v].words[32*i +: 32], (i == vecs[v].nw - 1), vecs[v].nb);
      end
      chk($sformatf("v%0d_dv", v), 128'(data_valid_o), 128'(1));
      chk($sformatf("v%0d_block", v), block_o, exp_b);
      chk($sformatf("v%0d_last", v), 128'(block_last_o), 128'(exp_l));
      step();
      step();
      chk($sformatf("v%0d_dv_wait", v), 128'(data_valid_o), 128'(0));
      chk($sformatf("v%0d_rdy_wait", v), 128'(word_ready_o), 128'(0));
      chk($sformatf("v%0d_hold", v), block_o, exp_b);
      pulse_done();
      if (PadEn && vecs[v].full) begin
        chk($sformatf("v%0d_pad_rdy", v), 128'(word_ready_o), 128'(0));
        chk($sformatf("v%0d_pad_dv0", v), 128'(data_valid_o), 128'(0));
        step();
        chk($sformatf("v%0d_pad_dv", v), 128'(data_valid_o), 128'(1));
        chk($sformatf("v%0d_pad_blk", v), block_o, 128'(1));
        chk($sformatf("v%0d_pad_last", v), 128'(block_last_o), 128'(1));
        step();
        pulse_done();
      end
      chk($sformatf("v%0d_free_rdy", v), 128'(word_ready_o), 128'(1));
      chk($sformatf("v%0d_clear", v), block_o, 128'(0));
    end

    // Pad-only request in idle FILL.
    pad_only_i = 1'b1;
    step();
    pad_only_i = 1'b0;
    chk("po_dv0", 128'(data_valid_o), 128'(0));
    step();
    chk("po_dv", 128'(data_valid_o), 128'(1));
    chk("po_block", block_o, PadEn ? 128'(1) : 128'(0));
    chk("po_last", 128'(block_last_o), 128'(1));
    step();
    pulse_done();
    chk("po_free", 128'(word_ready_o), 128'(1));

    // Spurious done in FILL, pad_only colliding with a word, pad_only at cnt!=0.
    done_man = 1'b1;
    step();
    done_man = 1'b0;
    chk("sp_rdy", 128'(word_ready_o), 128'(1));
    chk("sp_dv", 128'(data_valid_o), 128'(0));
    pad_only_i = 1'b1;
    send_word(32'hAAAA0001, 1'b0, 3'd0);
    pad_only_i = 1'b0;
    step();
    chk("pw_dv", 128'(data_valid_o), 128'(0));
    chk("pw_rdy", 128'(word_ready_o), 128'(1));
    pad_only_i = 1'b1;
    step();
    pad_only_i = 1'b0;
    step();
    chk("pc_dv", 128'(data_valid_o), 128'(0));
    chk("pc_rdy", 128'(word_ready_o), 128'(1));
    send_word(32'hAAAA0002, 1'b0, 3'd0);
    send_word(32'hAAAA0003, 1'b0, 3'd0);
    send_word(32'hAAAA0004, 1'b0, 3'd0);
    chk("pw_blk_dv", 128'(data_valid_o), 128'(1));
    chk("pw_blk", block_o, 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001);
    chk("pw_last", 128'(block_last_o), 128'(0));
    // Host holds the next word through WAIT.
    word_i       = 32'h76543210;
    word_last_i  = 1'b1;
    word_bytes_i = 3'd4;
    word_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("hold_rdy%0d", c), 128'(word_ready_o), 128'(0));
      chk($sformatf("hold_blk%0d", c), block_o, 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001);
    end
    done_man = 1'b1;
    step();
    done_man = 1'b0;
    chk("hold_free", 128'(word_ready_o), 128'(1));
    step();
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
    chk("slot0_dv", 128'(data_valid_o), 128'(1));
    chk("slot0_blk", block_o, PadEn ? 128'h00000000_00000000_00000001_76543210
                                    : 128'h00000000_00000000_00000000_76543210);
    chk("slot0_last", 128'(block_last_o), 128'(1));
    step();
    pulse_done();

    // Reset in WAIT with a pad block pending.
    for (int i = 0; i < 4; i++) send_word(32'h01010101 * (i + 1), (i == 3), 3'd4);
    step();
    #2;
    resetb = 1'b0;
    #1;
    chk("rw_rdy", 128'(word_ready_o), 128'(1));
    chk("rw_dv", 128'(data_valid_o), 128'(0));
    chk("rw_blk", block_o, 128'(0));
    chk("rw_last", 128'(block_last_o), 128'(0));
    @(negedge clk);
    resetb = 1'b1;
    base = dv_count;
    for (int c = 0; c < 3; c++) step();
    chk("rw_no_pulse", 128'(dv_count - base), 128'(0));
    send_word(32'h0000BEEF, 1'b1, 3'd2);
    step();
    pulse_done();
    chk("rw_nopad_rdy", 128'(word_ready_o), 128'(1));
    chk("rw_nopad_dv", 128'(data_valid_o), 128'(0));

    // Back-to-back eight words with automatic block_done.
    auto_en = 1'b1;
    base    = dv_count;
    b2b_words = '0;
    for (int i = 0; i < 8; i++) send_word(32'h1000_0000 + 32'(i), 1'b0, 3'd0);
    for (int c = 0; c < 8; c++) step();
    auto_en = 1'b0;
    chk("b2b_pulses", 128'(dv_count - base), 128'(2));
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) b2b_words[32*i +: 32] = 32'h1000_0000 + 32'(4 * b + i);
      chk($sformatf("b2b_blk%0d", b), cap_block[(base + b) % 8], b2b_words);
      chk($sformatf("b2b_last%0d", b), 128'(cap_last[(base + b) % 8]), 128'(0));
    end
    chk("b2b_rdy", 128'(word_ready_o), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
